// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage dcache access controller.
package mem_access_ctrl_pkg;

    typedef logic [31:0] word_t;

    // IDLE/ACCESS may issue a request, DONE waits for the latch to move on,
    // HALTED is absorbing until reset.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } memctl_state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-cache request/response bus between the MEM stage and the dcache.
interface mem_access_ctrl_if;
    import mem_access_ctrl_pkg::*;

    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  dhit;
    word_t dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );

endinterface

// File: rtl/mem_access_ctrl_perf_counter.sv
// Free-running event counter with enable; wraps modulo 2^CNT_W.
module mem_access_ctrl_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count one per enabled cycle; natural overflow gives the wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns the latched load/store controls into a single
// dcache request, stalls the front of the pipe until dhit, feeds MEM/WB.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int          CNT_W          = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 memread_in,
    input  logic                 memwrite_in,
    input  word_t                addr_in,
    input  word_t                store_in,
    input  logic                 halt_in,
    input  logic                 advance,
    input  logic                 flush,
    mem_access_ctrl_if.master    dbus,
    output logic                 mem_stall,
    output word_t                load_data,
    output logic                 halted,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     ld_cnt,
    output logic [CNT_W-1:0]     st_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    memctl_state_t state_q, state_d;
    word_t         load_q, load_d;
    logic [31:0]   wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;

    // Ungated versions feed registers; nRST gating is applied only at the
    // outputs so the request drops the instant reset asserts.
    logic pending, req_rd, req_wr, stall_c, rd_hit, wr_hit;

    // Request decode: write wins when both controls are set.
    always_comb begin
        pending = (memread_in | memwrite_in) & ~flush
                  & ((state_q == IDLE) | (state_q == ACCESS));
        req_wr  = pending & memwrite_in;
        req_rd  = pending & memread_in & ~memwrite_in;
        stall_c = pending & ~dbus.dhit;
        rd_hit  = dbus.dhit & req_rd;
        wr_hit  = dbus.dhit & req_wr;

        dbus.dmemWEN   = req_wr & nRST;
        dbus.dmemREN   = req_rd & nRST;
        dbus.dmemaddr  = addr_in;
        dbus.dmemstore = store_in;
        mem_stall      = stall_c & nRST;
        load_data      = (rd_hit & nRST) ? dbus.dmemload : load_q;
        halted         = (state_q == HALTED);
        timeout_err    = timeout_q;
    end

    // Next state, wait counter, sticky timeout and load capture.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        load_d     = load_q;

        if (rd_hit) load_d = dbus.dmemload;
        if (pending & memread_in & memwrite_in) timeout_d = 1'b1;

        case (state_q)
            IDLE, ACCESS: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (pending) begin
                    if (dbus.dhit) begin
                        state_d = advance ? IDLE : DONE;
                    end else begin
                        state_d = ACCESS;
                        if (state_q == ACCESS) begin
                            wait_cnt_d = wait_cnt_q + 32'd1;
                            if (wait_cnt_d == TO_LAST) timeout_d = 1'b1;
                        end
                    end
                end else if (halt_in) begin
                    state_d = HALTED;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (advance | flush) state_d = IDLE;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and capture registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            load_q     <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    mem_access_ctrl_perf_counter #(.CNT_W(CNT_W)) u_ld_cnt (
        .CLK(CLK), .nRST(nRST), .en_i(rd_hit), .cnt_o(ld_cnt)
    );

    mem_access_ctrl_perf_counter #(.CNT_W(CNT_W)) u_st_cnt (
        .CLK(CLK), .nRST(nRST), .en_i(wr_hit), .cnt_o(st_cnt)
    );

    mem_access_ctrl_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK(CLK), .nRST(nRST), .en_i(stall_c), .cnt_o(stall_cnt)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random transactions,
// checked against a transaction-level reference model.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        memread_in, memwrite_in, halt_in, advance, flush;
    logic [31:0] addr_in, store_in, load_data;
    logic [31:0] ld_cnt, st_cnt, stall_cnt;
    logic        mem_stall, halted, timeout_err;

    mem_access_ctrl_if dbus();

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .memread_in(memread_in), .memwrite_in(memwrite_in),
        .addr_in(addr_in), .store_in(store_in),
        .halt_in(halt_in), .advance(advance), .flush(flush),
        .dbus(dbus),
        .mem_stall(mem_stall), .load_data(load_data),
        .halted(halted), .timeout_err(timeout_err),
        .ld_cnt(ld_cnt), .st_cnt(st_cnt), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: "served" means the latched instruction already got its
    // dhit and is only waiting for the latch to move on.
    bit          m_served, m_halted, m_timeout, m_active;
    int          m_waits;
    logic [31:0] m_ld, m_st, m_stall, m_last_load;
    logic        e_ren, e_wen, e_stall;
    logic [31:0] e_load;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_served = 0; m_halted = 0; m_timeout = 0; m_waits = 0;
        m_ld = 0; m_st = 0; m_stall = 0; m_last_load = 0;
    endtask

    task automatic model_comb();
        if (!nRST) model_reset();
        m_active = nRST && !m_halted && !m_served && !flush && (memread_in || memwrite_in);
        e_wen    = m_active && memwrite_in;
        e_ren    = m_active && memread_in && !memwrite_in;
        e_stall  = m_active && !dbus.dhit;
        e_load   = (dbus.dhit && e_ren) ? dbus.dmemload : m_last_load;
    endtask

    task automatic model_edge();
        if (!nRST) begin
            model_reset();
        end else if (!m_halted) begin
            if (m_active && memread_in && memwrite_in) m_timeout = 1;
            if (flush) begin
                m_served = 0;
                m_waits  = 0;
            end else if (m_served) begin
                if (advance) m_served = 0;
            end else if (m_active) begin
                if (dbus.dhit) begin
                    if (e_ren) begin
                        m_ld = m_ld + 1;
                        m_last_load = dbus.dmemload;
                    end
                    if (e_wen) m_st = m_st + 1;
                    m_served = !advance;
                    m_waits  = 0;
                end else begin
                    m_stall = m_stall + 1;
                    m_waits = m_waits + 1;
                    if (m_waits == TO) m_timeout = 1;
                end
            end else begin
                m_waits = 0;
                if (halt_in) m_halted = 1;
            end
        end
    endtask

    // One clock: inputs already set at a negedge; ends at the next negedge.
    task automatic step();
        #1;
        model_comb();
        check("dmemREN",   dbus.dmemREN, e_ren);
        check("dmemWEN",   dbus.dmemWEN, e_wen);
        check("mem_stall", mem_stall,    e_stall);
        check("load_data", load_data,    e_load);
        check("dmemaddr",  dbus.dmemaddr, addr_in);
        check("halted",    halted,       m_halted);
        @(posedge CLK);
        model_edge();
        #1;
        check("ld_cnt",      ld_cnt,      m_ld);
        check("st_cnt",      st_cnt,      m_st);
        check("stall_cnt",   stall_cnt,   m_stall);
        check("timeout_err", timeout_err, m_timeout);
        check("halted_q",    halted,      m_halted);
        @(negedge CLK);
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        memread_in = rd; memwrite_in = wr; addr_in = a; store_in = d;
    endtask

    task automatic idle(input int n);
        set_op(0, 0, 32'h0, 32'h0);
        dbus.dhit = 0; advance = 1; flush = 0; halt_in = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int kind, lat, hold;
        nRST = 0; halt_in = 0; advance = 0; flush = 0;
        set_op(0, 0, 32'h0, 32'h0);
        dbus.dhit = 0; dbus.dmemload = 32'h0;
        model_reset();
        @(negedge CLK);
        step();
        nRST = 1;
        idle(1);

        // Load hit in the issue cycle with advance
        set_op(1, 0, 32'h40, 32'h0);
        dbus.dhit = 1; dbus.dmemload = 32'hDEADBEEF; advance = 1;
        #1 check("t1_load_now", load_data, 32'hDEADBEEF);
        step();
        check("t1_ld_cnt", ld_cnt, 32'd1);
        set_op(0, 0, 32'h0, 32'h0); dbus.dhit = 0;
        #1 check("t1_load_held", load_data, 32'hDEADBEEF);
        idle(1);

        // Store, dhit after 3 wait cycles, latch held 2 more cycles
        set_op(0, 1, 32'h80, 32'h12345678); advance = 0; dbus.dhit = 0;
        #1 check("t2_store_data", dbus.dmemstore, 32'h12345678);
        for (int i = 0; i < 3; i++) step();
        dbus.dhit = 1;
        step();
        dbus.dhit = 0;
        #1 check("t2_wen_done", dbus.dmemWEN, 1'b0);
        step();
        advance = 1;
        step();
        check("t2_st_cnt", st_cnt, 32'd1);
        check("t2_stall_cnt", stall_cnt, 32'd3);
        idle(1);

        // Flush in the second ACCESS cycle
        set_op(1, 0, 32'h44, 32'h0); advance = 0;
        for (int i = 0; i < 2; i++) step();
        flush = 1;
        #1 check("t3_ren_flush", dbus.dmemREN, 1'b0);
        check("t3_stall_flush", mem_stall, 1'b0);
        step();
        check("t3_ld_cnt", ld_cnt, 32'd1);
        idle(2);

        // Random transactions
        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 19);
            set_op((kind < 8) || (kind == 19), (kind >= 8 && kind < 16) || (kind == 19),
                   $urandom, $urandom);
            lat  = $urandom_range(0, 5);
            hold = $urandom_range(0, 2);
            for (int c = 0; c <= lat + hold; c++) begin
                dbus.dhit     = (c == lat);
                dbus.dmemload = $urandom;
                advance       = (c == lat + hold);
                flush         = ($urandom_range(0, 19) == 0);
                halt_in       = 0;
                step();
            end
        end
        idle(1);

        // Timeout: dhit withheld 6 cycles, then completes
        nRST = 0;
        step();
        nRST = 1;
        idle(1);
        set_op(1, 0, 32'h100, 32'h0); advance = 1; dbus.dhit = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 3) check("t4_not_yet", timeout_err, 1'b0);
            if (i == 4) check("t4_set", timeout_err, 1'b1);
        end
        #1 check("t4_still_req", dbus.dmemREN, 1'b1);
        dbus.dhit = 1; dbus.dmemload = 32'hCAFEF00D;
        step();
        check("t4_sticky", timeout_err, 1'b1);
        check("t4_ld_cnt", ld_cnt, 32'd1);
        idle(1);

        // Reset in the middle of an access
        set_op(1, 0, 32'h200, 32'h0); advance = 0; dbus.dhit = 0;
        for (int i = 0; i < 2; i++) step();
        nRST = 0;
        #1 check("t6_ren_rst", dbus.dmemREN, 1'b0);
        check("t6_stall_cnt", stall_cnt, 32'd0);
        check("t6_ld_cnt", ld_cnt, 32'd0);
        check("t6_timeout", timeout_err, 1'b0);
        step();
        nRST = 1;
        idle(1);

        // Halt with no memory op
        halt_in = 1;
        step();
        check("t5_halted", halted, 1'b1);
        halt_in = 0;
        set_op(1, 0, 32'h300, 32'h0); dbus.dhit = 0;
        #1 check("t5_no_ren", dbus.dmemREN, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("t5_still_halted", halted, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline latch outputs in the 5-stage MIPS pipeline.
- Turns the latched load/store controls into a dcache request, holds it until dhit, and stalls the front of the pipeline while the request is outstanding.
- Issues exactly one request per latched instruction and supplies load data to the MEM/WB latch.
- Keeps load/store/stall performance counters and a timeout flag.

Parameters:
- TIMEOUT_CYCLES, 64: wait-cycle count at which timeout_err sets.
- CNT_W, 32: width of the performance counters.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- memread_in  in  1  latched M_MemRead
- memwrite_in  in  1  latched M_MemWrite
- addr_in  in  32  latched ALU output (byte address)
- store_in  in  32  latched store data
- halt_in  in  1  latched halt
- advance  in  1  EX/MEM latch loads a new instruction at the next edge
- flush  in  1  EX/MEM flush
- dhit  in  1  dcache done
- dmemload  in  32  dcache read data
- dmemREN  out  1  dcache read request
- dmemWEN  out  1  dcache write request
- dmemaddr  out  32  = addr_in
- dmemstore  out  32  = store_in
- mem_stall  out  1  hold IF/ID, ID/EX and EX/MEM (their WEN forced low)
- load_data  out  32  to MEM/WB
- halted  out  1  processor halted
- timeout_err  out  1  sticky
- ld_cnt, st_cnt, stall_cnt  out  CNT_W  performance counters

Behaviour:
- States: IDLE, ACCESS, DONE, HALTED.
- Reset (async): state IDLE, load_q=0, all counters 0, timeout_err=0, wait_cnt=0.
- Under reset, combinational outputs are dmemREN=dmemWEN=0, mem_stall=0, halted=0, load_data=0.
- pending = (memread_in | memwrite_in) & !flush & (state ∈ {IDLE, ACCESS}).
- Requests:
  - dmemWEN = pending & memwrite_in.
  - dmemREN = pending & memread_in & !memwrite_in. Write has priority if both are set; a both-set cycle also sets timeout_err.
- Zero-latency issue: requests are asserted in the same cycle the latch presents the op.
- mem_stall = pending & !dhit. Stall drops in the dhit cycle so the pipeline may advance on that edge.
- load_data = (dhit & dmemREN) ? dmemload : load_q. load_q captures dmemload on any dhit with dmemREN.
- IDLE:
  - flush → IDLE.
  - halt_in & !pending → HALTED.
  - pending & dhit & advance → IDLE.
  - pending & dhit & !advance → DONE.
  - pending & !dhit → ACCESS.
- ACCESS:
  - Same dhit/advance exits as IDLE.
  - wait_cnt increments each cycle without dhit; wait_cnt clears on exit.
  - wait_cnt reaching TIMEOUT_CYCLES-1 sets timeout_err. The request is not aborted.
- DONE: requests suppressed, so no double store. advance or flush → IDLE.
- HALTED: absorbing until reset. Requests and stall are 0; halted=1.
- flush in ACCESS/DONE → IDLE next edge; request outputs gate off in the flush cycle itself. No cache state is committed without dhit.
- Counters:
  - ld_cnt increments on dhit with dmemREN.
  - st_cnt increments on dhit with dmemWEN.
  - stall_cnt increments each cycle mem_stall=1.
  - All counters wrap modulo 2^CNT_W.
- Async reset during ACCESS drops the request immediately.

Decomposition:
- Shared cpu_types_pkg: memctl_state_t enum, word_t reuse.
- One sub-module: perf_counter (enable, wrap, async reset), instantiated three times.

Test Plan:
- Load, dhit same cycle, advance=1: addr 0x40, dmemload 0xDEADBEEF → dmemREN=1 for 1 cycle, mem_stall=0, load_data=0xDEADBEEF that cycle, ld_cnt=1, state IDLE.
- Store with dhit after 3 cycles, advance=0 held 2 more cycles: store 0x12345678 @0x80 → mem_stall=1 for 3 cycles, dmemWEN deasserted in DONE, st_cnt=1, stall_cnt=3.
- Flush in 2nd ACCESS cycle → dmemREN=0 that cycle, IDLE next, ld_cnt=0, no stall.
- TIMEOUT_CYCLES=4, dhit withheld 6 cycles → timeout_err=1 after 4th wait cycle, request still asserted, completes on dhit, flag stays set.
- halt_in with no mem op → halted=1 next edge; later memread_in=1 produces no dmemREN.
- nRST asserted mid-ACCESS → dmemREN=0 immediately, counters 0, state IDLE.
